// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin front end for a single i2c_master: grants one
// transaction at a time, forwards TX bytes, and reports done/err per requester.
//
// state  | meaning
// IDLE   | waiting for a request, ready driven to the winner only
// LAUNCH | parameters latched, m_start pulsed for one cycle
// RUN    | TX bytes forwarded to the master, watchdog counting
// FINISH | done/err reported to the granted requester, rr pointer flipped
module i2c_txn_arbiter #(
  parameter logic [15:0] TO_CYC = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  input  logic [6:0] req0_addr,
  input  logic       req0_rw,
  input  logic [3:0] req0_cnt,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  output logic       req0_pop,
  output logic       req0_done,
  output logic       req0_err,

  input  logic       req1_valid,
  input  logic [6:0] req1_addr,
  input  logic       req1_rw,
  input  logic [3:0] req1_cnt,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       req1_pop,
  output logic       req1_done,
  output logic       req1_err,

  output logic       m_start,
  output logic       m_abort,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [3:0] m_data_cnt,
  output logic [7:0] m_data_in,
  input  logic       i_txff_rd,
  input  logic       m_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]  state;
  logic [1:0]  gnt;
  logic        rr;
  logic [4:0]  pop_cnt;
  logic [15:0] wdog;
  logic        overrun;
  logic        err_q;

  logic        in_idle;
  logic        in_launch;
  logic        in_run;
  logic        in_fin;
  logic        any_valid;
  logic        win;
  logic [4:0]  cnt_ext;
  logic        pop_ok;
  logic        pop_over;
  logic [4:0]  pop_nxt;
  logic        done_ok;
  logic        timeout;
  logic        done_err;

  // Every strobe is gated by rst so nothing leaks out during the reset cycle.
  always_comb begin
    in_idle   = (state == IDLE) && !rst;
    in_launch = (state == LAUNCH) && !rst;
    in_run    = (state == RUN) && !rst;
    in_fin    = (state == FINISH) && !rst;
    any_valid = req0_valid || req1_valid;
    win       = (req0_valid && req1_valid) ? rr : !req0_valid;
    cnt_ext   = {1'b0, m_data_cnt};
    pop_ok    = in_run && i_txff_rd && (pop_cnt != cnt_ext);
    pop_over  = in_run && i_txff_rd && (pop_cnt == cnt_ext);
    pop_nxt   = pop_cnt + {4'd0, pop_ok};
    done_ok   = in_run && m_done;
    timeout   = in_run && !m_done && (wdog == TO_CYC);
    // Reads only fail on overrun; writes must also have consumed every byte.
    done_err  = overrun || pop_over || (!m_rw && (pop_nxt != cnt_ext));
  end

  assign req0_ready = in_idle && any_valid && !win;
  assign req1_ready = in_idle && any_valid && win;
  assign req0_pop   = pop_ok && gnt[0];
  assign req1_pop   = pop_ok && gnt[1];
  assign req0_done  = in_fin && gnt[0];
  assign req1_done  = in_fin && gnt[1];
  assign req0_err   = in_fin && gnt[0] && err_q;
  assign req1_err   = in_fin && gnt[1] && err_q;
  assign m_start    = in_launch;
  assign m_abort    = timeout;
  assign m_data_in  = in_run ? (gnt[1] ? req1_data : req0_data) : 8'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 2'b00;
      rr         <= 1'b0;
      pop_cnt    <= 5'd0;
      wdog       <= 16'd0;
      overrun    <= 1'b0;
      err_q      <= 1'b0;
      m_addr     <= 7'd0;
      m_rw       <= 1'b0;
      m_data_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt        <= win ? 2'b10 : 2'b01;
            m_addr     <= win ? req1_addr : req0_addr;
            m_rw       <= win ? req1_rw : req0_rw;
            m_data_cnt <= win ? req1_cnt : req0_cnt;
            pop_cnt    <= 5'd0;
            overrun    <= 1'b0;
            err_q      <= 1'b0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wdog  <= 16'd0;
          state <= RUN;
        end
        RUN: begin
          pop_cnt <= pop_nxt;
          wdog    <= wdog + 16'd1;
          if (pop_over) overrun <= 1'b1;
          if (done_ok) begin
            err_q <= done_err;
            state <= FINISH;
          end else if (timeout) begin
            err_q <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH: begin
          rr    <= gnt[0];
          gnt   <= 2'b00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter: requesters and master are modelled at
// transaction level (who wins, how many pops land, what err must be).
module tb_i2c_txn_arbiter;

  localparam logic [15:0] TO = 16'd20;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] v;
  logic [1:0] pend;
  logic [6:0] ad [2];
  logic [1:0] rw;
  logic [3:0] cn [2];
  logic [7:0] mem [2][16];
  logic [3:0] idx [2];
  logic       txrd;
  logic       mdone;

  wire [1:0] rdy, pop, dn, er;
  wire       m_start, m_abort, m_rw;
  wire [6:0] m_addr;
  wire [3:0] m_cnt;
  wire [7:0] m_din;
  wire [7:0] d0 = mem[0][idx[0]];
  wire [7:0] d1 = mem[1][idx[1]];

  int n_chk;
  int n_pass;
  int rr_m;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_addr(ad[0]), .req0_rw(rw[0]), .req0_cnt(cn[0]),
    .req0_data(d0), .req0_ready(rdy[0]), .req0_pop(pop[0]), .req0_done(dn[0]),
    .req0_err(er[0]),
    .req1_valid(v[1]), .req1_addr(ad[1]), .req1_rw(rw[1]), .req1_cnt(cn[1]),
    .req1_data(d1), .req1_ready(rdy[1]), .req1_pop(pop[1]), .req1_done(dn[1]),
    .req1_err(er[1]),
    .m_start(m_start), .m_abort(m_abort), .m_addr(m_addr), .m_rw(m_rw),
    .m_data_cnt(m_cnt), .m_data_in(m_din), .i_txff_rd(txrd), .m_done(mdone)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic r, input logic [3:0] c);
    ad[i] = a; rw[i] = r; cn[i] = c; idx[i] = 4'd0; pend[i] = 1'b1;
    for (int k = 0; k < 16; k++) mem[i][k] = 8'($urandom);
  endtask

  task automatic new_reqs();
    int r;
    for (int i = 0; i < 2; i++) begin
      if (!pend[i] && $urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 9);
        set_req(i, 7'($urandom), 1'($urandom),
                (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(1, 14)));
      end
    end
    if (pend == 2'b00) set_req($urandom_range(0, 1), 7'($urandom), 1'b0, 4'($urandom_range(0, 15)));
  endtask

  task automatic run_idle(input int w, inout bit adv);
    @(negedge clk);
    if (adv) idx[w]++;
    adv = 0; txrd = 1'b0; mdone = 1'b0;
    #1;
    chk("gap_pop", pop, 0);
    chk("gap_abort", m_abort, 0);
    chk("gap_data", m_din, mem[w][idx[w]]);
  endtask

  // One full transaction starting at the IDLE cycle; np_in < 0 picks pops randomly.
  task automatic do_txn(input int np_in, input bit to_mode);
    int w, np, k, c;
    bit exp_err, adv;
    logic [6:0] a_w;
    @(negedge clk);
    v = pend;
    w = (v[0] && v[1]) ? rr_m : (v[0] ? 0 : 1);
    c = int'(cn[w]);
    a_w = ad[w];
    txrd = 1'($urandom); mdone = 1'($urandom);
    #1;
    chk("ready_win", rdy[w], 1);
    chk("ready_lose", rdy[1-w], 0);
    chk("idle_pop", pop, 0);
    chk("idle_done", dn, 0);

    @(negedge clk);
    v[w] = 1'b0; pend[w] = 1'b0;
    txrd = 1'($urandom); mdone = 1'($urandom);
    #1;
    chk("m_start", m_start, 1);
    chk("m_addr", m_addr, a_w);
    chk("m_rw", m_rw, rw[w]);
    chk("m_data_cnt", m_cnt, cn[w]);
    chk("launch_pop", pop, 0);
    chk("launch_rdy", rdy, 0);

    if (np_in >= 0) np = np_in;
    else begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: np = rw[w] ? 0 : c;
        4:          np = c + 1;
        default:    np = $urandom_range(0, c);
      endcase
    end

    k = 0; adv = 0;
    for (int p = 0; p < np; p++) begin
      if (!to_mode && np <= 8 && $urandom_range(0, 1) == 1) begin
        run_idle(w, adv); k++;
      end
      @(negedge clk);
      if (adv) idx[w]++;
      txrd = 1'b1; mdone = 1'b0;
      #1;
      chk("pop_w", pop[w], (p < c) ? 1 : 0);
      chk("pop_l", pop[1-w], 0);
      chk("m_data_in", m_din, mem[w][idx[w]]);
      chk("abort_run", m_abort, 0);
      adv = (p < c);
      k++;
    end

    if (!to_mode) begin
      if (np <= 8 && $urandom_range(0, 1) == 1) begin
        run_idle(w, adv); k++;
      end
      @(negedge clk);
      if (adv) idx[w]++;
      adv = 0; txrd = 1'b0; mdone = 1'b1;
      #1;
      chk("abort_done", m_abort, 0);
      exp_err = (np > c) || (!rw[w] && np != c);
    end else begin
      while (k < int'(TO)) begin
        run_idle(w, adv); k++;
      end
      @(negedge clk);
      if (adv) idx[w]++;
      adv = 0; txrd = 1'b0; mdone = 1'b0;
      #1;
      chk("abort_to", m_abort, 1);
      exp_err = 1;
    end

    @(negedge clk);
    mdone = 1'b0; txrd = 1'($urandom);
    #1;
    chk("done_w", dn[w], 1);
    chk("err_w", er[w], exp_err);
    chk("done_l", dn[1-w], 0);
    chk("err_l", er[1-w], 0);
    chk("fin_abort", m_abort, 0);
    chk("fin_pop", pop, 0);
    chk("fin_addr", m_addr, a_w);
    txrd = 1'b0;
    rr_m = 1 - w;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; rr_m = 0;
    v = 2'b00; pend = 2'b00; rw = 2'b00; txrd = 1'b0; mdone = 1'b0; rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ad[i] = 7'd0; cn[i] = 4'd0; idx[i] = 4'd0;
      for (int k = 0; k < 16; k++) mem[i][k] = 8'd0;
    end

    // Requests visible while reset is held must not be acknowledged.
    v = 2'b11;
    repeat (3) @(negedge clk);
    txrd = 1'b1; mdone = 1'b1;
    #1;
    chk("rst_ready", rdy, 0);
    chk("rst_start", m_start, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_data", m_din, 0);
    chk("rst_pop", pop, 0);
    chk("rst_done", dn, 0);
    v = 2'b00; txrd = 1'b0; mdone = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Round-robin: simultaneous pair, then pending loser, then another pair.
    set_req(0, 7'h11, 1'b0, 4'd2);
    set_req(1, 7'h22, 1'b1, 4'd3);
    do_txn(-1, 0);
    set_req(0, 7'h33, 1'b0, 4'd1);
    do_txn(-1, 0);
    set_req(1, 7'h44, 1'b0, 4'd2);
    do_txn(-1, 0);
    do_txn(-1, 0);

    set_req(0, 7'h50, 1'b0, 4'd3);
    mem[0][0] = 8'hA1; mem[0][1] = 8'hB2; mem[0][2] = 8'hC3;
    do_txn(3, 0);
    set_req(0, 7'h12, 1'b0, 4'd2);
    do_txn(3, 0);
    set_req(1, 7'h2a, 1'b1, 4'd4);
    do_txn(0, 0);
    set_req(0, 7'h0f, 1'b0, 4'd0);
    do_txn(0, 0);
    set_req(1, 7'h61, 1'b0, 4'd5);
    do_txn(2, 1);

    // Reset in the middle of a RUN: everything drops, no completion reported.
    set_req(0, 7'h3c, 1'b0, 4'd3);
    @(negedge clk);
    v = pend;
    #1;
    chk("mid_ready", rdy, 2'b01);
    @(negedge clk);
    v[0] = 1'b0; pend[0] = 1'b0;
    #1;
    chk("mid_start", m_start, 1);
    @(negedge clk);
    txrd = 1'b1;
    #1;
    chk("mid_pop", pop, 2'b01);
    @(negedge clk);
    idx[0]++;
    txrd = 1'b1; mdone = 1'b1; rst = 1'b1;
    set_req(1, 7'h45, 1'b1, 4'd1);
    #1;
    chk("mid_rst_pop", pop, 0);
    chk("mid_rst_data", m_din, 0);
    chk("mid_rst_done", dn, 0);
    chk("mid_rst_err", er, 0);
    chk("mid_rst_abort", m_abort, 0);
    chk("mid_rst_start", m_start, 0);
    @(negedge clk);
    rst = 1'b0; txrd = 1'b0; mdone = 1'b0;
    #1;
    chk("post_rst_addr", m_addr, 0);
    chk("post_rst_cnt", m_cnt, 0);
    chk("post_rst_done", dn, 0);
    chk("post_rst_start", m_start, 0);
    rr_m = 0;
    do_txn(-1, 0);

    for (int t = 0; t < 60; t++) begin
      new_reqs();
      do_txn(-1, ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 Parameter TO_CYC, default 16'd50000, RUN-state watchdog limit in clk cycles; 16-bit counter.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has a transaction pending; held until accepted.
REQ-005 reqN_addr  input  7  7-bit slave address, stable while valid.
REQ-006 reqN_rw  input  1  1=read, 0=write.
REQ-007 reqN_cnt  input  4  byte count, 0..15.
REQ-008 reqN_data  input  8  current TX byte; requester advances on reqN_pop.
REQ-009 reqN_ready  output  1  accept strobe for requester N.
REQ-010 reqN_pop  output  1  one-cycle strobe: current TX byte consumed.
REQ-011 reqN_done  output  1  one-cycle completion strobe.
REQ-012 reqN_err  output  1  qualifies reqN_done; 1 = transaction failed.
REQ-013 m_start  output  1  one-cycle launch strobe to i2c_master.
REQ-014 m_abort  output  1  one-cycle abort strobe to i2c_master.
REQ-015 m_addr, m_rw, m_data_cnt  output  7/1/4  latched parameters driven to i2c_master addr, rw, data_cnt.
REQ-016 m_data_in  output  8  byte driven to i2c_master data_in.
REQ-017 i_txff_rd  input  1  byte-consumed strobe from i2c_master.
REQ-018 m_done  input  1  transaction-complete strobe from i2c_master.

Function
REQ-019 FSM states IDLE, LAUNCH, RUN, FINISH; exactly one grant (gnt) active outside IDLE.
REQ-020 IDLE: winner = requester with valid; if both valid, winner = rr pointer; reqN_ready asserted combinationally for winner only.
REQ-021 Accept on edge with valid&&ready: latch addr/rw/cnt into m_*, set gnt, clear pop counter, go LAUNCH.
REQ-022 LAUNCH: m_start=1 exactly one cycle, then RUN; m_start first high the cycle after acceptance.
REQ-023 RUN: m_data_in = reqGNT_data combinationally; other requester's data ignored.
REQ-024 RUN: reqGNT_pop = i_txff_rd same cycle, pop counter (5-bit) increments; non-granted pop stays 0.
REQ-025 i_txff_rd when pop counter already equals latched cnt: pop suppressed, overrun flag set.
REQ-026 i_txff_rd outside RUN: ignored, no pop.
REQ-027 RUN: watchdog increments each cycle; cleared on entry to RUN.
REQ-028 m_done in RUN -> FINISH; err = overrun OR (rw==0 AND pops != cnt).
REQ-029 Watchdog reaching TO_CYC without m_done -> m_abort=1 one cycle, err=1, go FINISH; m_done and timeout in same cycle: m_done wins, no abort.
REQ-030 FINISH: reqGNT_done=1 and reqGNT_err per REQ-028/029 for one cycle; rr pointer set to other requester; return IDLE, gnt cleared.
REQ-031 m_done outside RUN: ignored.
REQ-032 cnt=0 legal: address-only transaction, zero pops expected.
REQ-033 Minimum spacing: new acceptance no earlier than the cycle after FINISH.
REQ-034 m_addr/m_rw/m_data_cnt stable from LAUNCH through FINISH.

Reset
REQ-035 rst=1 at edge: state IDLE, rr pointer=requester 0, counters 0, flags 0, m_addr/m_rw/m_data_cnt=0.
REQ-036 During and after reset all strobes (ready, pop, done, err, m_start, m_abort) = 0, m_data_in=0.
REQ-037 Reset mid-transaction: abandon silently, no done, no m_abort.

Verification
REQ-038 req0 write addr=0x50 cnt=3, data A1,B2,C3; master pops 3 then m_done -> m_start one cycle after accept, req0_pop x3, m_data_in A1/B2/C3, req0_done=1 err=0.
REQ-039 req0 and req1 valid same cycle after reset -> req0 granted first; req1 accepted in IDLE after req0 FINISH; third simultaneous pair -> req0 granted again (rr alternates).
REQ-040 Write cnt=2, master pops 3 then m_done -> 2 pops forwarded, third suppressed, done with err=1.
REQ-041 TO_CYC=20, no m_done -> m_abort and done with err=1 exactly 20 cycles after RUN entry.
REQ-042 rst asserted in RUN after 1 pop -> all outputs 0 next cycle, no done; req1 pending afterwards accepted from IDLE normally.
REQ-043 Read cnt=4, no pops, m_done -> done with err=0; cnt=0 write with m_done -> err=0.
